// File: rtl/vga_buffer_arbiter.sv
// Single-port frame-buffer RAM arbiter: display reads first, then posted capture writes (FIFO) and debug access.
// Display reads return in a fixed two cycles; debug preempts the FIFO only when starved and the FIFO is below high water.
module vga_buffer_arbiter #(
  parameter int ADDR_W       = 17,
  parameter int DATA_W       = 12,
  parameter int WFIFO_DEPTH  = 4,
  parameter int HIGH_WATER   = 3,
  parameter int DBG_MAX_WAIT = 15
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic              RD_REQ,
  input  logic [ADDR_W-1:0] RD_ADDR,
  output logic              RD_VALID,
  output logic [DATA_W-1:0] RD_DATA,
  input  logic              WR_REQ,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              WR_FULL,
  output logic              WR_OVERFLOW,
  input  logic              OVF_CLR,
  input  logic              DBG_REQ,
  input  logic              DBG_WE,
  input  logic [ADDR_W-1:0] DBG_ADDR,
  input  logic [DATA_W-1:0] DBG_WDATA,
  output logic              DBG_ACK,
  output logic [DATA_W-1:0] DBG_RDATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA
);
  localparam int PTR_W  = (WFIFO_DEPTH > 1) ? $clog2(WFIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = (DBG_MAX_WAIT > 0) ? $clog2(DBG_MAX_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(WFIFO_DEPTH);
  localparam logic [CNT_W-1:0]  HW_C    = CNT_W'(HIGH_WATER);
  localparam logic [WAIT_W-1:0] WMAX_C  = WAIT_W'(DBG_MAX_WAIT);

  typedef enum logic [2:0] {D_IDLE, D_WAIT, D_ISSUE, D_RDATA, D_DONE} dbg_state_e;

  logic [ADDR_W-1:0] fifo_addr_q [WFIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [WFIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              full_q, ovf_q;

  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_tag_q, rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;

  dbg_state_e        dbg_state_q;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic              dbg_we_q, dbg_ack_q;
  logic [DATA_W-1:0] dbg_rdata_q;

  logic dbg_wait, fifo_empty, dbg_urgent;
  logic gnt_rd, gnt_dbg, gnt_fifo, push, pop;

  always_comb begin
    dbg_wait   = (dbg_state_q == D_WAIT);
    fifo_empty = (cnt_q == '0);
    dbg_urgent = dbg_wait && (wait_cnt_q >= WMAX_C) && (cnt_q < HW_C);
    gnt_rd     = RD_REQ;
    gnt_dbg    = !RD_REQ && dbg_wait && (dbg_urgent || fifo_empty);
    gnt_fifo   = !RD_REQ && !gnt_dbg && !fifo_empty;
    pop        = gnt_fifo;
    // A full FIFO still accepts a write when its head retires in the same cycle.
    push       = WR_REQ && ((cnt_q != DEPTH_C) || pop);
    cnt_d      = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= WR_ADDR;
      fifo_data_q[wr_ptr_q] <= WR_DATA;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == DEPTH_C);
      if (WR_REQ && !push) begin
        ovf_q <= 1'b1;
      end else if (OVF_CLR) begin
        ovf_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_tag_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_tag_q <= 1'b0;
      if (gnt_rd) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= RD_ADDR;
        rd_tag_q   <= 1'b1;
      end else if (gnt_dbg) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= DBG_WE;
        mem_addr_q <= DBG_ADDR;
        if (DBG_WE) mem_wdata_q <= DBG_WDATA;
      end else if (gnt_fifo) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= fifo_addr_q[rd_ptr_q];
        mem_wdata_q <= fifo_data_q[rd_ptr_q];
      end else begin
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
      // Only display-tagged returns surface on the read port.
      rd_valid_q <= mem_en_q && !mem_we_q && rd_tag_q;
      if (rd_valid_q) rd_data_q <= MEM_RDATA;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      dbg_state_q <= D_IDLE;
      wait_cnt_q  <= '0;
      dbg_we_q    <= 1'b0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      case (dbg_state_q)
        D_IDLE: begin
          dbg_ack_q  <= 1'b0;
          wait_cnt_q <= '0;
          if (DBG_REQ) dbg_state_q <= D_WAIT;
        end
        D_WAIT: begin
          if (gnt_dbg) begin
            dbg_state_q <= D_ISSUE;
            wait_cnt_q  <= '0;
            dbg_we_q    <= DBG_WE;
            dbg_ack_q   <= DBG_WE;
          end else if (wait_cnt_q < WMAX_C) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
          end
        end
        D_ISSUE: begin
          dbg_ack_q   <= !dbg_we_q;
          dbg_state_q <= dbg_we_q ? D_DONE : D_RDATA;
        end
        D_RDATA: begin
          dbg_ack_q   <= 1'b0;
          dbg_rdata_q <= MEM_RDATA;
          dbg_state_q <= D_DONE;
        end
        D_DONE: begin
          dbg_ack_q <= 1'b0;
          // Wait for the requester to drop so a held request is not re-issued.
          if (!DBG_REQ) dbg_state_q <= D_IDLE;
        end
        default: begin
          dbg_ack_q   <= 1'b0;
          dbg_state_q <= D_IDLE;
        end
      endcase
    end
  end

  assign RD_VALID    = rd_valid_q;
  assign RD_DATA     = rd_valid_q ? MEM_RDATA : rd_data_q;
  assign WR_FULL     = full_q;
  assign WR_OVERFLOW = ovf_q;
  assign DBG_ACK     = dbg_ack_q;
  assign DBG_RDATA   = (dbg_state_q == D_RDATA) ? MEM_RDATA : dbg_rdata_q;
  assign MEM_EN      = mem_en_q;
  assign MEM_WE      = mem_we_q;
  assign MEM_ADDR    = mem_addr_q;
  assign MEM_WDATA   = mem_wdata_q;

endmodule

// File: tb/tb_vga_buffer_arbiter.sv
// Bench for vga_buffer_arbiter with a behavioural synchronous RAM preloaded to addr*3.
// Expected display reads and RAM writes are queued at stimulus time and retired by a negedge monitor.
`timescale 1ns/1ps
module tb_vga_buffer_arbiter;
  localparam int AW = 17;
  localparam int DW = 12;
  localparam int MAXW = 15;

  logic          CLK, nRESET;
  logic          RD_REQ, RD_VALID, WR_REQ, WR_FULL, WR_OVERFLOW, OVF_CLR;
  logic          DBG_REQ, DBG_WE, DBG_ACK, MEM_EN, MEM_WE;
  logic [AW-1:0] RD_ADDR, WR_ADDR, DBG_ADDR, MEM_ADDR;
  logic [DW-1:0] RD_DATA, WR_DATA, DBG_WDATA, DBG_RDATA, MEM_WDATA, MEM_RDATA;

  vga_buffer_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WFIFO_DEPTH(4), .HIGH_WATER(3), .DBG_MAX_WAIT(MAXW)) dut (
    .CLK(CLK), .nRESET(nRESET),
    .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_VALID(RD_VALID), .RD_DATA(RD_DATA),
    .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL),
    .WR_OVERFLOW(WR_OVERFLOW), .OVF_CLR(OVF_CLR),
    .DBG_REQ(DBG_REQ), .DBG_WE(DBG_WE), .DBG_ADDR(DBG_ADDR), .DBG_WDATA(DBG_WDATA),
    .DBG_ACK(DBG_ACK), .DBG_RDATA(DBG_RDATA),
    .MEM_EN(MEM_EN), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bit [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge CLK) begin
    if (MEM_EN === 1'b1) begin
      if (MEM_WE === 1'b1) mem[MEM_ADDR] = MEM_WDATA;
      else MEM_RDATA <= mem[MEM_ADDR];
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [DW-1:0]    exp_rd [$];
  logic [AW+DW-1:0] exp_wr [$];
  int               we_cyc [$];
  int errors = 0, checks = 0;
  int we_count = 0, rv_count = 0, ack_count = 0, last_we_cyc = 0, last_ack_cyc = 0;
  logic [DW-1:0]    mon_rd_e;
  logic [AW+DW-1:0] mon_wr_e;

  always @(negedge CLK) begin
    if (RD_VALID === 1'b1) begin
      rv_count++;
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: RD_VALID with RD_DATA=%h, none expected (cycle %0d)", RD_DATA, cyc);
      end else begin
        mon_rd_e = exp_rd.pop_front();
        if (RD_DATA !== mon_rd_e) begin
          errors++;
          $display("FAIL rd_data: got %h, expected %h (cycle %0d)", RD_DATA, mon_rd_e, cyc);
        end
      end
    end
    if (MEM_WE === 1'b1) begin
      we_count++;
      we_cyc.push_back(cyc);
      last_we_cyc = cyc;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: MEM_WE addr=%h data=%h, none expected (cycle %0d)", MEM_ADDR, MEM_WDATA, cyc);
      end else begin
        mon_wr_e = exp_wr.pop_front();
        if ({MEM_ADDR, MEM_WDATA} !== mon_wr_e) begin
          errors++;
          $display("FAIL wr_order: got addr=%h data=%h, expected addr=%h data=%h (cycle %0d)",
                   MEM_ADDR, MEM_WDATA, mon_wr_e[AW+DW-1:DW], mon_wr_e[DW-1:0], cyc);
        end
      end
    end
    if (DBG_ACK === 1'b1) begin
      ack_count++;
      last_ack_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    RD_REQ = 0; RD_ADDR = '0; WR_REQ = 0; WR_ADDR = '0; WR_DATA = '0; OVF_CLR = 0;
    DBG_REQ = 0; DBG_WE = 0; DBG_ADDR = '0; DBG_WDATA = '0;
  endtask

  task automatic test_reset();
    nRESET = 0;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if ({RD_VALID, WR_FULL, WR_OVERFLOW, DBG_ACK, MEM_EN, MEM_WE} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, expected 000000", {RD_VALID, WR_FULL, WR_OVERFLOW, DBG_ACK, MEM_EN, MEM_WE});
    end
    checks++;
    if (RD_DATA !== '0) begin errors++; $display("FAIL reset_rd_data: got %h, expected 0", RD_DATA); end
    checks++;
    if (DBG_RDATA !== '0) begin errors++; $display("FAIL reset_dbg_rdata: got %h, expected 0", DBG_RDATA); end
    checks++;
    if (MEM_ADDR !== '0) begin errors++; $display("FAIL reset_mem_addr: got %h, expected 0", MEM_ADDR); end
    checks++;
    if (MEM_WDATA !== '0) begin errors++; $display("FAIL reset_mem_wdata: got %h, expected 0", MEM_WDATA); end
    nRESET = 1;
    repeat (2) tick();
  endtask

  task automatic test_display();
    logic exp_v;
    for (int c = 0; c < 12; c++) begin
      RD_REQ = (c < 8);
      RD_ADDR = AW'(c);
      if (c < 8) exp_rd.push_back(DW'(c * 3));
      @(negedge CLK);
      exp_v = (c >= 2 && c < 10);
      checks++;
      if (RD_VALID !== exp_v) begin
        errors++;
        $display("FAIL display_valid: cycle %0d RD_VALID=%b, expected %b", c, RD_VALID, exp_v);
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (exp_rd.size() != 0) begin errors++; $display("FAIL display_drain: %0d reads outstanding, expected 0", exp_rd.size()); end
  endtask

  task automatic test_collision();
    int b;
    we_cyc.delete();
    b = cyc;
    for (int c = 0; c < 36; c++) begin
      RD_REQ = (c < 30 && c != 10 && c != 20);
      RD_ADDR = AW'(c);
      if (RD_REQ) exp_rd.push_back(DW'(c * 3));
      WR_REQ = (c >= 2 && c <= 4);
      WR_ADDR = AW'(17'h100 + c - 2);
      WR_DATA = DW'(12'hA01 + c - 2);
      if (WR_REQ) exp_wr.push_back({WR_ADDR, WR_DATA});
      tick();
    end
    idle_inputs();
    checks++;
    if (we_cyc.size() != 3) begin
      errors++;
      $display("FAIL collision_count: %0d RAM writes, expected 3", we_cyc.size());
    end else begin
      checks++;
      if (we_cyc[0] - b != 11) begin errors++; $display("FAIL collision_first: write at cycle %0d, expected 11", we_cyc[0] - b); end
      checks++;
      if (we_cyc[1] - b != 21) begin errors++; $display("FAIL collision_second: write at cycle %0d, expected 21", we_cyc[1] - b); end
      checks++;
      if (we_cyc[2] - b != 31) begin errors++; $display("FAIL collision_third: write at cycle %0d, expected 31", we_cyc[2] - b); end
    end
    checks++;
    if (WR_OVERFLOW !== 1'b0) begin errors++; $display("FAIL collision_ovf: WR_OVERFLOW=%b, expected 0", WR_OVERFLOW); end
    checks++;
    if (exp_rd.size() != 0 || exp_wr.size() != 0) begin
      errors++;
      $display("FAIL collision_drain: rd=%0d wr=%0d outstanding, expected 0", exp_rd.size(), exp_wr.size());
    end
  endtask

  task automatic test_overflow();
    for (int c = 0; c < 22; c++) begin
      RD_REQ = (c < 10);
      RD_ADDR = AW'(c);
      if (RD_REQ) exp_rd.push_back(DW'(c * 3));
      WR_REQ = (c >= 1 && c <= 5);
      WR_ADDR = AW'(17'h180 + c - 1);
      WR_DATA = DW'(12'hB00 + c - 1);
      if (c >= 1 && c <= 4) exp_wr.push_back({WR_ADDR, WR_DATA});
      OVF_CLR = (c == 7);
      @(negedge CLK);
      if (c == 4) begin
        checks++;
        if (WR_FULL !== 1'b0) begin errors++; $display("FAIL ovf_full_early: WR_FULL=%b after 3 writes, expected 0", WR_FULL); end
      end
      if (c == 5) begin
        checks++;
        if ({WR_FULL, WR_OVERFLOW} !== 2'b10) begin
          errors++;
          $display("FAIL ovf_full: {WR_FULL,WR_OVERFLOW}=%b after 4 writes, expected 10", {WR_FULL, WR_OVERFLOW});
        end
      end
      if (c == 6) begin
        checks++;
        if (WR_OVERFLOW !== 1'b1) begin errors++; $display("FAIL ovf_set: WR_OVERFLOW=%b after 5th write, expected 1", WR_OVERFLOW); end
      end
      if (c == 8) begin
        checks++;
        if (WR_OVERFLOW !== 1'b0) begin errors++; $display("FAIL ovf_clr: WR_OVERFLOW=%b after OVF_CLR, expected 0", WR_OVERFLOW); end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (WR_FULL !== 1'b0 || exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL ovf_drain: WR_FULL=%b wr=%0d rd=%0d outstanding, expected 0/0/0", WR_FULL, exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_dbg_starve();
    bit got = 0;
    int ack_c = -1;
    for (int c = 0; c < 60; c++) begin
      RD_REQ = (c < 2);
      RD_ADDR = AW'(c);
      if (RD_REQ) exp_rd.push_back(DW'(c * 3));
      WR_REQ = !got;
      WR_ADDR = AW'(17'h200 + c);
      WR_DATA = DW'(c);
      if (WR_REQ) exp_wr.push_back({WR_ADDR, WR_DATA});
      DBG_REQ = (c >= 2) && !got;
      DBG_WE = 0;
      DBG_ADDR = 17'h00040;
      @(negedge CLK);
      if (DBG_ACK === 1'b1 && !got) begin
        got = 1;
        ack_c = c;
        checks++;
        if (DBG_RDATA !== 12'h0C0) begin errors++; $display("FAIL starve_data: DBG_RDATA=%h, expected 0c0", DBG_RDATA); end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (!got || ack_c - 2 > MAXW + 3) begin
      errors++;
      $display("FAIL starve_latency: ack seen=%0b after %0d cycles, expected within %0d", got, ack_c - 2, MAXW + 3);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL starve_drain: wr=%0d rd=%0d outstanding, expected 0", exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_dbg_highwater();
    bit got = 0;
    int ack_c = -1;
    for (int c = 0; c < 60; c++) begin
      RD_REQ = (c < 3);
      RD_ADDR = AW'(c);
      if (RD_REQ) exp_rd.push_back(DW'(c * 3));
      WR_REQ = (c < 33);
      WR_ADDR = AW'(17'h280 + c);
      WR_DATA = DW'(12'h300 + c);
      if (WR_REQ) exp_wr.push_back({WR_ADDR, WR_DATA});
      DBG_REQ = (c >= 3) && !got;
      DBG_WE = 0;
      DBG_ADDR = 17'h00040;
      @(negedge CLK);
      if (DBG_ACK === 1'b1 && !got) begin
        got = 1;
        ack_c = c;
        checks++;
        if (DBG_RDATA !== 12'h0C0) begin errors++; $display("FAIL hw_data: DBG_RDATA=%h, expected 0c0", DBG_RDATA); end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (ack_c != 36) begin
      errors++;
      $display("FAIL hw_ack_cycle: ack at cycle %0d, expected 36 (after FIFO drops below high water)", ack_c);
    end
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL hw_drain: wr=%0d rd=%0d outstanding, expected 0", exp_wr.size(), exp_rd.size());
    end
  endtask

  task automatic test_dbg_handshake();
    int ack0 = ack_count, we0 = we_count, rv0 = rv_count;
    int ack_c = 1000;
    exp_wr.push_back({17'h1FFFF, 12'hFFF});
    for (int c = 0; c < 20; c++) begin
      DBG_REQ = (c <= ack_c + 6);
      DBG_WE = 1;
      DBG_ADDR = 17'h1FFFF;
      DBG_WDATA = 12'hFFF;
      @(negedge CLK);
      if (DBG_ACK === 1'b1 && ack_c == 1000) ack_c = c;
      tick();
    end
    idle_inputs();
    checks++;
    if (ack_count - ack0 != 1) begin errors++; $display("FAIL hs_ack_pulses: %0d DBG_ACK pulses, expected 1", ack_count - ack0); end
    checks++;
    if (we_count - we0 != 1) begin errors++; $display("FAIL hs_we_count: %0d RAM writes, expected 1", we_count - we0); end
    checks++;
    if (ack_c != 2 || last_we_cyc != last_ack_cyc) begin
      errors++;
      $display("FAIL hs_write_timing: ack at %0d (we cycle %0d, ack cycle %0d), expected ack at 2 with MEM_WE", ack_c, last_we_cyc, last_ack_cyc);
    end
    ack_c = 1000;
    for (int c = 0; c < 12; c++) begin
      DBG_REQ = (ack_c == 1000);
      DBG_WE = 0;
      DBG_ADDR = 17'h1FFFF;
      @(negedge CLK);
      if (DBG_ACK === 1'b1 && ack_c == 1000) begin
        ack_c = c;
        checks++;
        if (DBG_RDATA !== 12'hFFF) begin errors++; $display("FAIL hs_read_data: DBG_RDATA=%h, expected fff", DBG_RDATA); end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (ack_c != 3) begin errors++; $display("FAIL hs_read_timing: ack at cycle %0d, expected 3", ack_c); end
    checks++;
    if (rv_count != rv0) begin errors++; $display("FAIL hs_no_rd_valid: %0d RD_VALID pulses, expected 0", rv_count - rv0); end
    checks++;
    if (DBG_RDATA !== 12'hFFF) begin errors++; $display("FAIL hs_rdata_hold: DBG_RDATA=%h, expected fff held", DBG_RDATA); end
  endtask

  task automatic test_async_reset();
    int we0, rv0;
    for (int c = 0; c < 2; c++) begin
      RD_REQ = 1;
      RD_ADDR = AW'(5 + c);
      WR_REQ = 1;
      WR_ADDR = AW'(17'h300 + c);
      WR_DATA = DW'(12'h111 * (c + 1));
      tick();
    end
    idle_inputs();
    we0 = we_count;
    rv0 = rv_count;
    nRESET = 0;
    #1;
    checks++;
    if ({RD_VALID, WR_FULL, WR_OVERFLOW, DBG_ACK, MEM_EN, MEM_WE} !== 6'b0 || MEM_ADDR !== '0 || RD_DATA !== '0) begin
      errors++;
      $display("FAIL areset_outputs: flags=%b MEM_ADDR=%h RD_DATA=%h, expected all 0",
               {RD_VALID, WR_FULL, WR_OVERFLOW, DBG_ACK, MEM_EN, MEM_WE}, MEM_ADDR, RD_DATA);
    end
    repeat (3) @(posedge CLK);
    #1;
    nRESET = 1;
    repeat (15) tick();
    checks++;
    if (we_count != we0 || rv_count != rv0) begin
      errors++;
      $display("FAIL areset_quiet: %0d writes %0d read returns after reset, expected 0 0", we_count - we0, rv_count - rv0);
    end
    for (int c = 0; c < 14; c++) begin
      RD_REQ = (c < 4);
      RD_ADDR = AW'(c);
      if (RD_REQ) exp_rd.push_back(DW'(c * 3));
      WR_REQ = (c < 4);
      WR_ADDR = AW'(17'h380 + c);
      WR_DATA = DW'(12'h700 + c);
      if (WR_REQ) exp_wr.push_back({WR_ADDR, WR_DATA});
      @(negedge CLK);
      if (c == 2) begin
        checks++;
        if (WR_FULL !== 1'b0) begin errors++; $display("FAIL areset_fifo_empty: WR_FULL=%b after 2 writes, expected 0", WR_FULL); end
      end
      tick();
    end
    idle_inputs();
    checks++;
    if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
      errors++;
      $display("FAIL areset_drain: wr=%0d rd=%0d outstanding, expected 0", exp_wr.size(), exp_rd.size());
    end
  endtask

  initial begin
    nRESET = 0;
    idle_inputs();
    for (int a = 0; a < (1 << AW); a++) mem[a] = DW'(a * 3);
    test_reset();
    test_display();
    test_collision();
    test_overflow();
    test_dbg_starve();
    test_dbg_highwater();
    test_dbg_handshake();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
